// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the round-robin mem arbiter.
package mem_arbiter_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned TMO_W   = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Width of a requester index; never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after rr_ptr, wrapping.
module mem_arbiter_rr_pick
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic            valid,
  output logic [IW-1:0]   gnt
);

  logic [IW-1:0] cand;

  // Scan from farthest to nearest so the nearest set bit after rr_ptr wins.
  always_comb begin
    valid = 1'b0;
    gnt   = '0;
    cand  = '0;
    for (int unsigned k = NREQ; k > 0; k--) begin
      cand = IW'((32'(rr_ptr) + k) % NREQ);
      if (req[cand]) begin
        valid = 1'b1;
        gnt   = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one 4-phase REQ/ACK mem port among NREQ requesters,
// with a watchdog that aborts a mem access that is never acknowledged.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [NREQ-1:0]  REQ,
  input  logic [NREQ-1:0]  WEN,
  input  logic [NREQ*AW-1:0] ADDR,
  input  logic [NREQ*DW-1:0] DIN,
  output logic [DW-1:0]    DOUT,
  output logic [NREQ-1:0]  ACK,
  output logic             ERR,
  output logic             M_REQ,
  output logic             M_WEN,
  output logic [AW-1:0]    M_ADDR,
  output logic [DW-1:0]    M_DIN,
  input  logic [DW-1:0]    M_DOUT,
  input  logic             M_ACK
);

  localparam int unsigned IW = idx_w(NREQ);

  state_t           state;
  logic [IW-1:0]    gnt;
  logic [IW-1:0]    rr_ptr;
  logic [TMO_W-1:0] tmo_cnt;
  logic [DW-1:0]    rdata;
  logic             err;
  logic             pick_valid;
  logic [IW-1:0]    pick_gnt;

  mem_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req    (REQ),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .gnt    (pick_gnt)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      gnt     <= '0;
      rr_ptr  <= IW'(NREQ - 1);
      tmo_cnt <= '0;
      rdata   <= '0;
      err     <= 1'b0;
      DOUT    <= '0;
      ACK     <= '0;
      ERR     <= 1'b0;
      M_REQ   <= 1'b0;
      M_WEN   <= 1'b0;
      M_ADDR  <= '0;
      M_DIN   <= '0;
    end else begin
      case (state)
        // Grant and latch the winner's request; its inputs are ignored afterwards.
        IDLE: begin
          if (pick_valid) begin
            gnt     <= pick_gnt;
            M_ADDR  <= ADDR[int'(pick_gnt)*AW +: AW];
            M_DIN   <= DIN[int'(pick_gnt)*DW +: DW];
            M_WEN   <= WEN[pick_gnt];
            M_REQ   <= 1'b1;
            tmo_cnt <= '0;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (M_ACK) begin
            M_REQ <= 1'b0;
            rdata <= M_WEN ? '0 : M_DOUT;
            err   <= 1'b0;
            state <= DRAIN;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
              M_REQ <= 1'b0;
              rdata <= '0;
              err   <= 1'b1;
              state <= DRAIN;
            end
          end
        end
        // Finish the mem-side handshake (including a late ACK) before answering.
        DRAIN: begin
          if (!M_ACK) begin
            ACK   <= NREQ'(1) << gnt;
            DOUT  <= rdata;
            ERR   <= err;
            state <= DONE;
          end
        end
        DONE: begin
          if (!REQ[gnt]) begin
            ACK    <= '0;
            ERR    <= 1'b0;
            DOUT   <= '0;
            rr_ptr <= gnt;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
